cuckoo_match_collector: RTL
===========================

# cuckoo_match_collector

- Sits directly downstream of the L1 cuckoo lookup stage (case and nocase paths).
- Re-aligns that stage's `compare_out`/`suffix` results with the byte window that produced them and tracks the in-packet byte offset.
- Packs every hit, plus an end-of-packet marker, into a small FWFT FIFO.
- The rule-verification stage drains the FIFO through a valid/ready handshake.

## Interface
Parameters:
- `LATENCY`, 4, cycles from `enable` high to the matching `compare_out` being valid; ≥2.
- `OFFSET_W`, 11, width of the byte-offset counter.
- `DEPTH`, 16, FIFO entries; power of two, ≥4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enable` in 1: same enable as the lookup stage; one byte window per cycle.
- `pkt_sop` in 1: first window of a packet; qualified by `enable`.
- `pkt_eop` in 1: last window of a packet; qualified by `enable`.
- `compare_out` in 2: case-path hit; bit0 = table A, bit1 = table B.
- `suffix` in 2: case-path suffix code.
- `compare_out_nocase` in 2: nocase-path hit.
- `suffix_nocase` in 2: nocase-path suffix code.
- `m_valid` out 1: head entry available.
- `m_ready` in 1: consumer accepts the head entry.
- `m_offset` out OFFSET_W: byte offset of the window in its packet.
- `m_hit` out 2: case hit bits.
- `m_suffix` out 2: case suffix code.
- `m_hit_nc` out 2: nocase hit bits.
- `m_suffix_nc` out 2: nocase suffix code.
- `m_last` out 1: entry closes a packet.
- `overflow` out 1: sticky; set when any entry is dropped.
- `drop_count` out 16: saturating count of dropped entries.

## Operation
Alignment:
- A delay line of LATENCY stages carries {v=`enable`, sop, eop}.
- It shifts every cycle and is not gated by `enable`.
- At its tail, aligned valid `av` qualifies the lookup outputs sampled that cycle.
- Lookup outputs are ignored when `av`=0, including the repeats produced while `enable` is low.

Packet FSM:
- IDLE:
  - `av`&sop → offset=0 → IN_PKT.
  - `av`&sop&eop → single-window packet; stays IDLE.
  - `av` without sop → discarded; no record, no count.
- IN_PKT:
  - Each `av` increments offset; it saturates at 2^OFFSET_W−1, no wrap.
  - `av`&eop → IDLE.
  - `av`&sop → offset restarts at 0; the previous packet is closed without a `m_last` record.

Record:
- Written on an `av` cycle in a packet (sop, IN_PKT, or eop) when `compare_out`≠0, `compare_out_nocase`≠0, or eop.
- Contents: {offset, case hit/suffix, nocase hit/suffix, last=eop}.
- Exactly one entry per window; case and nocase share the entry.

FIFO:
- Write accepted when not full, or when full and a pop happens in the same cycle.
- Otherwise the record is dropped (eop records included): `overflow`←1 and `drop_count`+1, saturating at 0xFFFF.
- `overflow` is cleared only by reset.
- Pop when `m_valid`&`m_ready`.
- Push and pop in the same cycle on an empty FIFO: the pushed entry is visible the next cycle; no bypass.

## Timing
- `enable` at cycle t with a hit → record written at t+LATENCY → `m_valid` at t+LATENCY+1 if the FIFO was empty.
- Head data is stable while `m_valid`&!`m_ready`.
- `m_offset`, `m_hit*`, `m_suffix*`, `m_last` are driven 0 whenever `m_valid`=0.
- Reset (`rst`=0 on a rising edge) acts the next cycle:
  - delay line, FSM (IDLE), offset, pointers, `overflow` and `drop_count` cleared;
  - all outputs 0;
  - in-flight lookups are discarded, even mid-packet.
- Full throughput: one record per cycle, sustained while `m_ready`=1.

## Structure
- Shared `cuckoo_pkg`:
  - hit-bit encoding constants (HIT_A=0, HIT_B=1);
  - record field localparams and total record width OFFSET_W+9;
  - FSM state enum {IDLE, IN_PKT}.
- One sub-module, `match_fifo`: synchronous FWFT FIFO (DEPTH, width), with pointers carrying an extra wrap bit, `full`/`empty`, and simultaneous push/pop.
- Delay line, FSM, offset counter and drop logic stay in the top module.

## Test plan
- LATENCY=4, sop at t=10, hit `compare_out`=2'b01 `suffix`=2'b10 on the 3rd window → `m_valid` at t=17: offset=2, `m_hit`=01, `m_suffix`=10, `m_last`=0.
- Same window hits case=10 and nocase=01 → one entry carrying both fields, not two.
- Single window with sop&eop and no hit → one entry: offset=0, `m_last`=1, all hit fields 0; FSM back in IDLE.
- `m_ready`=0, 20 consecutive hit windows with DEPTH=16 → 16 entries kept, `drop_count`=4, `overflow`=1; then drain → offsets 0..15 in order.
- FIFO full with `m_ready`=1 and a hit each cycle → zero drops; `drop_count` stays 0.
- `rst`=0 for one cycle mid-packet with 3 entries queued → `m_valid`=0 next cycle; windows without sop after reset produce no entries.

Source files
------------

// File: rtl/cuckoo_pkg.sv
// cuckoo_pkg: hit encodings, match record layout and packet FSM states
// shared by the cuckoo match collector and its FIFO.
package cuckoo_pkg;
   localparam int HIT_A = 0;
   localparam int HIT_B = 1;
   localparam int REC_LAST    = 0;
   localparam int REC_SFX_NC  = 1;
   localparam int REC_HIT_NC  = 3;
   localparam int REC_SFX     = 5;
   localparam int REC_HIT     = 7;
   localparam int REC_OFF     = 9;
   localparam int REC_FIXED_W = 9;
   typedef enum logic {IDLE, IN_PKT} pkt_state_e;
   function automatic int rec_width(input int offset_w);
      return offset_w + REC_FIXED_W;
   endfunction
endpackage

// File: rtl/match_fifo.sv
// match_fifo: synchronous first-word-fall-through FIFO; pointers carry a
// wrap bit so full and empty are distinguished without a counter.
module match_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   logic do_push, do_pop;
   always_comb begin
      empty = wptr == rptr;
      full = wptr == {~rptr[AW], rptr[AW-1:0]};
      do_pop = pop & ~empty;
      do_push = push & (~full | do_pop);
      dout = mem[rptr[AW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + (AW+1)'(1);
         if (do_pop) rptr <= rptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk)
      if (do_push) mem[wptr[AW-1:0]] <= din;
endmodule

// File: rtl/cuckoo_match_collector.sv
// cuckoo_match_collector: re-aligns cuckoo lookup hits with their byte window,
// tracks in-packet offset and queues one record per hit or end-of-packet.
module cuckoo_match_collector
   import cuckoo_pkg::*;
#(
   parameter int LATENCY  = 4,
   parameter int OFFSET_W = 11,
   parameter int DEPTH    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                pkt_sop,
   input  logic                pkt_eop,
   input  logic [1:0]          compare_out,
   input  logic [1:0]          suffix,
   input  logic [1:0]          compare_out_nocase,
   input  logic [1:0]          suffix_nocase,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [OFFSET_W-1:0] m_offset,
   output logic [1:0]          m_hit,
   output logic [1:0]          m_suffix,
   output logic [1:0]          m_hit_nc,
   output logic [1:0]          m_suffix_nc,
   output logic                m_last,
   output logic                overflow,
   output logic [15:0]         drop_count
);
   localparam int REC_W = rec_width(OFFSET_W);
   logic [LATENCY-1:0][2:0] dl;
   logic av, a_sop, a_eop, in_win, rec_v, push, pop, full, empty;
   pkt_state_e state, state_n;
   logic [OFFSET_W-1:0] offset, cur_off;
   logic [REC_W-1:0] rec, head;
   // the delay line free-runs so it stays in lockstep with the lookup pipeline
   always_ff @(posedge clk) begin
      if (!rst) begin
         dl <= '0;
         state <= IDLE;
         offset <= '0;
         overflow <= 1'b0;
         drop_count <= '0;
      end else begin
         dl <= {dl[LATENCY-2:0], {enable, enable & pkt_sop, enable & pkt_eop}};
         state <= state_n;
         if (in_win) offset <= cur_off;
         if (rec_v & ~push) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         end
      end
   end
   always_comb begin
      {av, a_sop, a_eop} = dl[LATENCY-1];
      in_win = av & (a_sop | (state == IN_PKT));
      cur_off = a_sop ? '0 : offset + OFFSET_W'(offset != '1);
      state_n = in_win ? (a_eop ? IDLE : IN_PKT) : state;
      rec_v = in_win & ((|compare_out) | (|compare_out_nocase) | a_eop);
      rec = {cur_off, compare_out, suffix, compare_out_nocase, suffix_nocase, a_eop};
      pop = ~empty & m_ready;
      push = rec_v & (~full | pop);
      m_valid = ~empty;
      m_offset = m_valid ? head[REC_OFF +: OFFSET_W] : '0;
      m_hit = m_valid ? head[REC_HIT +: 2] : '0;
      m_suffix = m_valid ? head[REC_SFX +: 2] : '0;
      m_hit_nc = m_valid ? head[REC_HIT_NC +: 2] : '0;
      m_suffix_nc = m_valid ? head[REC_SFX_NC +: 2] : '0;
      m_last = m_valid & head[REC_LAST];
   end
   match_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (rec),
      .pop  (pop),
      .dout (head),
      .full (full),
      .empty(empty)
   );
endmodule
